// File: rtl/cs_window_average.sv
// cs_window_average
//
// Sliding-window magnitude averager with a carrier-sense decision. Each
// accepted sample enters a circular buffer. An exact running sum over the
// last L = 2^win_sel samples is maintained, and the mean is the truncated
// sum >> win_sel. A hysteresis comparator on the mean drives `busy`.
//
// Partial windows are handled by a fill counter. Samples not yet written
// since the last flush count as zero. The buffer itself is never cleared.
//
// Ports:
//   clk        : the only clock.
//   rst        : synchronous, active-high reset.
//   in_data    : unsigned magnitude sample (DWIDTH).
//   in_valid   : sample strobe. There is no back-pressure: a sample is
//                accepted in every cycle in_valid is high, except in a
//                flush cycle, where the sample is discarded.
//   win_sel    : log2 of the window length. Values above LOG2_MAX_WIN are
//                clamped. The value is registered, and a change flushes
//                the averaging state one cycle later.
//   clear      : synchronous flush of the averaging state.
//   thresh_hi  : busy-set threshold (mean >= thresh_hi sets busy).
//   thresh_lo  : busy-clear threshold (mean < thresh_lo clears busy).
//   sum_out    : running window sum (SWIDTH).
//   mean_out   : sum_out >> clamped win_sel.
//   out_valid  : one-cycle pulse when sum_out/mean_out update.
//   primed     : the window has been completely filled since the last flush.
//   busy       : carrier-sense decision.
//   peak_out   : maximum primed mean since the last flush.
//
// Configuration macro: CS_PEAK_HOLD_EN builds the peak-hold register.
// Without it, peak_out is tied to 0.

module cs_window_average #(
    parameter int DWIDTH        = 16,
    parameter int LOG2_MAX_WIN  = 6,
    localparam int SWIDTH       = DWIDTH + LOG2_MAX_WIN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DWIDTH-1:0]   in_data,
    input  logic                in_valid,
    input  logic [3:0]          win_sel,
    input  logic                clear,
    input  logic [DWIDTH-1:0]   thresh_hi,
    input  logic [DWIDTH-1:0]   thresh_lo,
    output logic [SWIDTH-1:0]   sum_out,
    output logic [DWIDTH-1:0]   mean_out,
    output logic                out_valid,
    output logic                primed,
    output logic                busy,
    output logic [DWIDTH-1:0]   peak_out
);

    localparam int D = 1 << LOG2_MAX_WIN;
    localparam logic [LOG2_MAX_WIN:0] FILL_ONE = {{LOG2_MAX_WIN{1'b0}}, 1'b1};

    logic [DWIDTH-1:0]       mem [D];
    logic [LOG2_MAX_WIN-1:0] wp;
    logic [LOG2_MAX_WIN:0]   fill;
    logic [3:0]              win_q;
    logic [3:0]              win_d;

    logic [3:0]              lg;
    logic [LOG2_MAX_WIN:0]   win_len;
    logic [LOG2_MAX_WIN-1:0] rd_idx;
    logic [DWIDTH-1:0]       old;
    logic [SWIDTH-1:0]       sum_next;
    logic [SWIDTH-1:0]       mean_shift;
    logic [DWIDTH-1:0]       mean_next;
    logic [LOG2_MAX_WIN:0]   fill_next;
    logic                    primed_next;
    logic                    busy_next;
    logic                    flush;
    logic                    accept;

    assign lg      = (win_q > 4'(LOG2_MAX_WIN)) ? 4'(LOG2_MAX_WIN) : win_q;
    assign win_len = FILL_ONE << lg;

    // The leaving sample sits L entries behind the write pointer. When
    // L == D the index wraps onto wp itself, which is the entry being
    // overwritten.
    assign rd_idx = wp - win_len[LOG2_MAX_WIN-1:0];
    assign old    = (fill < win_len) ? '0 : mem[rd_idx];

    // Exact: the sum never holds more than L <= D samples.
    assign sum_next = sum_out + {{LOG2_MAX_WIN{1'b0}}, in_data}
                              - {{LOG2_MAX_WIN{1'b0}}, old};
    assign mean_shift  = sum_next >> lg;
    assign mean_next   = mean_shift[DWIDTH-1:0];
    assign fill_next   = (fill < win_len) ? fill + FILL_ONE : fill;
    assign primed_next = (fill_next == win_len);

    // Any change of the registered window invalidates the running sum.
    assign flush  = clear || (win_q != win_d);
    assign accept = in_valid && !flush;

    // Hysteresis: the set test comes first, so it wins when the thresholds
    // are inverted.
    always_comb begin
        busy_next = busy;
        if (primed_next) begin
            if (mean_next >= thresh_hi) begin
                busy_next = 1'b1;
            end else if (mean_next < thresh_lo) begin
                busy_next = 1'b0;
            end
        end
    end

    // Storage has no reset so that it can map onto RAM.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[wp] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_sel;
        if (rst) begin
            // Load both stages so that a stable win_sel does not flush
            // right after reset.
            win_d     <= win_sel;
            wp        <= '0;
            fill      <= '0;
            sum_out   <= '0;
            mean_out  <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            win_d <= win_q;
            if (flush) begin
                wp        <= '0;
                fill      <= '0;
                sum_out   <= '0;
                mean_out  <= '0;
                out_valid <= 1'b0;
                primed    <= 1'b0;
                busy      <= 1'b0;
            end else if (in_valid) begin
                wp        <= wp + 1'b1;
                fill      <= fill_next;
                sum_out   <= sum_next;
                mean_out  <= mean_next;
                out_valid <= 1'b1;
                primed    <= primed_next;
                busy      <= busy_next;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CS_PEAK_HOLD_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            peak_out <= '0;
        end else if (in_valid && primed_next && (mean_next > peak_out)) begin
            peak_out <= mean_next;
        end
    end
`else
    assign peak_out = '0;
`endif

endmodule

// File: tb/tb_cs_window_average.sv
// Testbench for cs_window_average. It uses a table of directed vectors,
// hand-written corner sequences and random traffic. A queue-based
// reference model predicts every output.

module tb_cs_window_average;

    localparam int DW = 16;
    localparam int LW = 6;
    localparam int SW = DW + LW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic [3:0]    win_sel;
    logic          clear;
    logic [DW-1:0] thresh_hi;
    logic [DW-1:0] thresh_lo;
    logic [SW-1:0] sum_out;
    logic [DW-1:0] mean_out;
    logic          out_valid;
    logic          primed;
    logic          busy;
    logic [DW-1:0] peak_out;

    int checks   = 0;
    int failures = 0;

    cs_window_average dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .win_sel(win_sel), .clear(clear), .thresh_hi(thresh_hi),
        .thresh_lo(thresh_lo), .sum_out(sum_out), .mean_out(mean_out),
        .out_valid(out_valid), .primed(primed), .busy(busy),
        .peak_out(peak_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned hist[$];      // samples accepted since the last flush (most recent 64)
    int          cnt;          // accepted since flush (saturating)
    int          m_sel_now;    // win_sel as seen one cycle ago
    int          m_sel_prev;   // win_sel as seen two cycles ago
    longint      e_sum;
    int          e_mean;
    int          e_ov;
    int          e_primed;
    int          e_busy;
    int          e_peak;

    function automatic void model_flush();
        hist.delete();
        cnt = 0;
        e_sum = 0; e_mean = 0; e_ov = 0; e_primed = 0; e_busy = 0; e_peak = 0;
    endfunction

    // Called once per clock edge with the inputs that were present at that edge.
    function automatic void model_edge();
        int  lg;
        int  len;
        int  n;
        bit  fl;
        if (rst) begin
            model_flush();
            m_sel_now  = int'(win_sel);
            m_sel_prev = int'(win_sel);
            return;
        end
        lg = (m_sel_now > LW) ? LW : m_sel_now;
        fl = clear || (m_sel_now != m_sel_prev);
        m_sel_prev = m_sel_now;
        m_sel_now  = int'(win_sel);
        if (fl) begin
            model_flush();
        end else if (in_valid) begin
            len = 1 << lg;
            hist.push_back(int'(in_data));
            if (hist.size() > 64) void'(hist.pop_front());
            if (cnt < 1000) cnt++;
            n = (hist.size() < len) ? hist.size() : len;
            e_sum = 0;
            for (int i = 0; i < n; i++) e_sum += hist[hist.size() - 1 - i];
            e_mean   = int'(e_sum >> lg);
            e_primed = (cnt >= len) ? 1 : 0;
            if (e_primed == 1) begin
                if (e_mean >= int'(thresh_hi)) e_busy = 1;
                else if (e_mean < int'(thresh_lo)) e_busy = 0;
                if (e_mean > e_peak) e_peak = e_mean;
            end
            e_ov = 1;
        end else begin
            e_ov = 0;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s @%0t: actual=0x%0h expected=0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        check_val("sum_out",   longint'(sum_out),   e_sum);
        check_val("mean_out",  longint'(mean_out),  longint'(e_mean));
        check_val("out_valid", longint'(out_valid), longint'(e_ov));
        check_val("primed",    longint'(primed),    longint'(e_primed));
        check_val("busy",      longint'(busy),      longint'(e_busy));
`ifdef CS_PEAK_HOLD_EN
        check_val("peak_out",  longint'(peak_out),  longint'(e_peak));
`else
        check_val("peak_out",  longint'(peak_out),  0);
`endif
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [DW-1:0] d, input logic clr);
        in_valid = v;
        in_data  = d;
        clear    = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] exp_sum;
        logic [DW-1:0] exp_mean;
        logic          exp_primed;
    } vec_t;

    vec_t vecs[5];
    logic [SW-1:0] full_sum;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
        win_sel = 4'd2; thresh_hi = 16'hFFFF; thresh_lo = 16'd0;
        m_sel_now = 2; m_sel_prev = 2;
        model_flush();

        // Reset: all outputs zero during and right after reset.
        step(1'b1, 16'd77, 1'b0);
        step(1'b1, 16'd77, 1'b0);
        rst = 1'b0;
        idle(2);

        // Directed table: window 4, samples 4..20.
        vecs[0] = '{16'd4,  22'd4,  16'd1,  1'b0};
        vecs[1] = '{16'd8,  22'd12, 16'd3,  1'b0};
        vecs[2] = '{16'd12, 22'd24, 16'd6,  1'b0};
        vecs[3] = '{16'd16, 22'd40, 16'd10, 1'b1};
        vecs[4] = '{16'd20, 22'd56, 16'd14, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, vecs[i].data, 1'b0);
            check_val("tbl_sum",    longint'(sum_out),  longint'(vecs[i].exp_sum));
            check_val("tbl_mean",   longint'(mean_out), longint'(vecs[i].exp_mean));
            check_val("tbl_primed", longint'(primed),   longint'(vecs[i].exp_primed));
        end
        idle(2);
        check_val("hold_sum", longint'(sum_out), 56);

        // Full-depth window with maximum samples: no overflow.
        win_sel = 4'd6;
        idle(3);
        for (int i = 0; i < 64; i++) step(1'b1, 16'hFFFF, 1'b0);
        full_sum = 22'(64 * 65535);
        check_val("full_sum",  longint'(sum_out),  longint'(full_sum));
        check_val("full_mean", longint'(mean_out), 65535);
        step(1'b1, 16'd0, 1'b0);
        check_val("wrap_sum",  longint'(sum_out),  longint'(63 * 65535));
        check_val("wrap_mean", longint'(mean_out), longint'((63 * 65535) / 64));

        // Hysteresis: window 8, thresholds 100/50.
        win_sel = 4'd3; thresh_hi = 16'd100; thresh_lo = 16'd50;
        idle(3);
        for (int i = 0; i < 8; i++) step(1'b1, 16'd120, 1'b0);
        check_val("busy_set", longint'(busy), 1);
        for (int i = 0; i < 8; i++) step(1'b1, 16'd70, 1'b0);
        check_val("busy_hold", longint'(busy), 1);
        for (int i = 0; i < 8; i++) step(1'b1, 16'd40, 1'b0);
        check_val("busy_clr", longint'(busy), 0);

        // Window change 3 -> 4 under continuous traffic.
        for (int i = 0; i < 8; i++) step(1'b1, 16'd120, 1'b0);
        win_sel = 4'd4;
        step(1'b1, 16'd120, 1'b0);        // still accepted with the old window
        step(1'b1, 16'd120, 1'b0);        // flush cycle, sample dropped
        check_val("chg_ov",     longint'(out_valid), 0);
        check_val("chg_sum",    longint'(sum_out),   0);
        check_val("chg_primed", longint'(primed),    0);
        for (int i = 0; i < 15; i++) step(1'b1, 16'd120, 1'b0);
        check_val("refill15", longint'(primed), 0);
        step(1'b1, 16'd120, 1'b0);
        check_val("refill16", longint'(primed), 1);

        // Clear with a coincident sample, then reset mid-window.
        step(1'b1, 16'd999, 1'b1);
        check_val("clr_sum", longint'(sum_out),   0);
        check_val("clr_ov",  longint'(out_valid), 0);
        step(1'b1, 16'd5, 1'b0);
        check_val("clr_first", longint'(sum_out), 5);
        step(1'b1, 16'd6, 1'b0);
        rst = 1'b1;
        step(1'b1, 16'd500, 1'b0);
        rst = 1'b0;
        check_val("rst_sum", longint'(sum_out), 0);
        step(1'b1, 16'd3, 1'b0);
        check_val("rst_first", longint'(sum_out), 3);

        // Peak hold with a one-sample window: means 30, 90, 60.
        win_sel = 4'd0; thresh_hi = 16'hFFFF; thresh_lo = 16'd0;
        idle(3);
        step(1'b1, 16'd30, 1'b0);
        step(1'b1, 16'd90, 1'b0);
        step(1'b1, 16'd60, 1'b0);
`ifdef CS_PEAK_HOLD_EN
        check_val("peak_final", longint'(peak_out), 90);
`else
        check_val("peak_final", longint'(peak_out), 0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 2) win_sel = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 99) < 5) begin
                thresh_hi = 16'($urandom_range(0, 40000));
                thresh_lo = 16'($urandom_range(0, 40000));
            end
            rst = ($urandom_range(0, 299) == 0);
            step(($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                 16'($urandom_range(0, 65535)),
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
